// File: rtl/hazard_ctrl.sv
// ----------------------------------------------------------------------------
// hazard_ctrl
//
// Purpose:
//   Pipeline hazard controller for the 5-stage core. It drives the enable and
//   synchronous-clear inputs of the pipeline registers, selects the operand
//   forwarding paths, and sequences multi-cycle data-memory stalls through a
//   small FSM. It also keeps saturating stall and flush event counters for
//   debug.
//
// Parameters:
//   TIMEOUT    maximum MEM_WAIT cycles before a memory error is flagged (>=2)
//   CNT_WIDTH  width of the stall/flush performance counters
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   RS1D_i, RS2D_i           source registers of the instruction in Decode
//   RS1E_i, RS2E_i           source registers of the instruction in Execute
//   RDE_i, RDM_i, RDW_i      destinations in Execute / Memory / Writeback
//   ResultSrcE_i             result select in Execute (2'b01 = load)
//   RegWriteM_i, RegWriteW_i register write enables in Memory / Writeback
//   PCSrcE_i                 taken branch/jump resolved in Execute
//   MemReqM_i, MemAckM_i     data-memory request / completion in Memory
//   EnF_o..EnW_o             pipeline register enables (PC, F-D, D-E, E-M, M-W)
//   ClrD_o, ClrE_o, ClrW_o   synchronous clears of F-D, D-E and M-W
//   ForwardAE_o, ForwardBE_o forwarding selects: 00 regfile, 01 W, 10 M
//   MemErr_o                 sticky memory-timeout flag
//   StallCnt_o, FlushCnt_o   saturating stall-cycle and flush-event counters
// ----------------------------------------------------------------------------
module hazard_ctrl #(
  parameter int TIMEOUT   = 64,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [4:0]           RS1D_i,
  input  logic [4:0]           RS2D_i,
  input  logic [4:0]           RS1E_i,
  input  logic [4:0]           RS2E_i,
  input  logic [4:0]           RDE_i,
  input  logic [4:0]           RDM_i,
  input  logic [4:0]           RDW_i,
  input  logic [1:0]           ResultSrcE_i,
  input  logic                 RegWriteM_i,
  input  logic                 RegWriteW_i,
  input  logic                 PCSrcE_i,
  input  logic                 MemReqM_i,
  input  logic                 MemAckM_i,
  output logic                 EnF_o,
  output logic                 EnD_o,
  output logic                 EnE_o,
  output logic                 EnM_o,
  output logic                 EnW_o,
  output logic                 ClrD_o,
  output logic                 ClrE_o,
  output logic                 ClrW_o,
  output logic [1:0]           ForwardAE_o,
  output logic [1:0]           ForwardBE_o,
  output logic                 MemErr_o,
  output logic [CNT_WIDTH-1:0] StallCnt_o,
  output logic [CNT_WIDTH-1:0] FlushCnt_o
);

  // Wide enough to hold TIMEOUT-1 with a spare bit of headroom.
  localparam int WaitW = $clog2(TIMEOUT) + 1;
  localparam logic [WaitW-1:0] WaitLast = WaitW'(TIMEOUT - 1);

  typedef enum logic {
    IDLE     = 1'b0,
    MEM_WAIT = 1'b1
  } state_e;

  state_e                 state_q,    state_d;
  logic [WaitW-1:0]       waitCnt_q,  waitCnt_d;
  logic                   memErr_q,   memErr_d;
  logic [CNT_WIDTH-1:0]   stallCnt_q, stallCnt_d;
  logic [CNT_WIDTH-1:0]   flushCnt_q, flushCnt_d;

  logic loadUse;
  logic memStall;
  logic flushTaken;

  // A load in Execute whose destination is read by the instruction in Decode
  // cannot be forwarded in time, so Decode must wait one cycle. x0 never
  // creates a dependency.
  assign loadUse = (ResultSrcE_i == 2'b01) && (RDE_i != 5'd0) &&
                   ((RDE_i == RS1D_i) || (RDE_i == RS2D_i));

  // The memory stall covers the request cycle itself as well as every
  // waiting cycle; the ack cycle is never stalled so the pipe moves on the
  // ack edge.
  assign memStall = ((state_q == IDLE)     && MemReqM_i && !MemAckM_i) ||
                    ((state_q == MEM_WAIT) && !MemAckM_i);

  // A redirect held in Execute during a memory stall is frozen there and is
  // acted on only once the stall releases.
  assign flushTaken = PCSrcE_i && !memStall;

  // Forwarding muxes. The Memory stage holds the younger result, so it wins
  // over Writeback when both match the same source register.
  always_comb begin
    ForwardAE_o = 2'b00;
    ForwardBE_o = 2'b00;

    if (RegWriteM_i && (RDM_i != 5'd0) && (RDM_i == RS1E_i)) begin
      ForwardAE_o = 2'b10;
    end else if (RegWriteW_i && (RDW_i != 5'd0) && (RDW_i == RS1E_i)) begin
      ForwardAE_o = 2'b01;
    end

    if (RegWriteM_i && (RDM_i != 5'd0) && (RDM_i == RS2E_i)) begin
      ForwardBE_o = 2'b10;
    end else if (RegWriteW_i && (RDW_i != 5'd0) && (RDW_i == RS2E_i)) begin
      ForwardBE_o = 2'b01;
    end
  end

  // Pipeline register control. Pipe registers give clear priority over
  // enable, so a register is never cleared while it is being held.
  always_comb begin
    EnF_o  = 1'b1;
    EnD_o  = 1'b1;
    EnE_o  = 1'b1;
    EnM_o  = 1'b1;
    EnW_o  = 1'b1;
    ClrD_o = 1'b0;
    ClrE_o = 1'b0;
    ClrW_o = 1'b0;

    if (memStall) begin
      // Freeze F..M and push a bubble into Writeback so the instruction
      // leaving Memory is not written back twice.
      EnF_o  = 1'b0;
      EnD_o  = 1'b0;
      EnE_o  = 1'b0;
      EnM_o  = 1'b0;
      ClrW_o = 1'b1;
    end else if (PCSrcE_i) begin
      // Squash the two wrong-path instructions; any load-use hazard belongs
      // to the squashed Decode instruction and is dropped.
      ClrD_o = 1'b1;
      ClrE_o = 1'b1;
    end else if (loadUse) begin
      // Hold Fetch/Decode one cycle and send a bubble into Execute.
      EnF_o  = 1'b0;
      EnD_o  = 1'b0;
      ClrE_o = 1'b1;
    end
  end

  // Memory-wait FSM. The wait counter counts cycles spent waiting for the
  // ack; on reaching TIMEOUT-1 the stall is abandoned and MemErr latches
  // until reset. An ack arriving after a timeout finds the FSM in IDLE with
  // no request and is therefore ignored.
  always_comb begin
    state_d   = state_q;
    waitCnt_d = waitCnt_q;
    memErr_d  = memErr_q;

    unique case (state_q)
      IDLE: begin
        if (MemReqM_i && !MemAckM_i) begin
          state_d   = MEM_WAIT;
          waitCnt_d = WaitW'(1);
        end
      end
      MEM_WAIT: begin
        if (MemAckM_i) begin
          state_d   = IDLE;
          waitCnt_d = '0;
        end else if (waitCnt_q == WaitLast) begin
          state_d   = IDLE;
          waitCnt_d = '0;
          memErr_d  = 1'b1;
        end else begin
          waitCnt_d = waitCnt_q + WaitW'(1);
        end
      end
      default: begin
        state_d   = IDLE;
        waitCnt_d = '0;
      end
    endcase
  end

  // Debug counters saturate at all-ones instead of wrapping so a long run
  // never reports a misleadingly small number.
  always_comb begin
    stallCnt_d = stallCnt_q;
    flushCnt_d = flushCnt_q;

    if (!EnF_o && (stallCnt_q != '1)) begin
      stallCnt_d = stallCnt_q + CNT_WIDTH'(1);
    end
    if (flushTaken && (flushCnt_q != '1)) begin
      flushCnt_d = flushCnt_q + CNT_WIDTH'(1);
    end
  end

  // State, wait counter, error flag and debug counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      waitCnt_q  <= '0;
      memErr_q   <= 1'b0;
      stallCnt_q <= '0;
      flushCnt_q <= '0;
    end else begin
      state_q    <= state_d;
      waitCnt_q  <= waitCnt_d;
      memErr_q   <= memErr_d;
      stallCnt_q <= stallCnt_d;
      flushCnt_q <= flushCnt_d;
    end
  end

  assign MemErr_o   = memErr_q;
  assign StallCnt_o = stallCnt_q;
  assign FlushCnt_o = flushCnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// ----------------------------------------------------------------------------
// tb_hazard_ctrl
//
// Self-checking bench for hazard_ctrl. Each cycle the stimulus is driven just
// after the rising edge, the expected outputs are computed from a small
// behavioural model of the controller and pushed into a queue, and at the
// falling edge the entry is popped and compared against the DUT.
// Small TIMEOUT and CNT_WIDTH make timeout and saturation reachable quickly.
// ----------------------------------------------------------------------------
module tb_hazard_ctrl;

  localparam int TO = 4;
  localparam int CW = 4;
  localparam int CntMax = (1 << CW) - 1;

  typedef struct packed {
    logic [4:0] rs1d;
    logic [4:0] rs2d;
    logic [4:0] rs1e;
    logic [4:0] rs2e;
    logic [4:0] rde;
    logic [4:0] rdm;
    logic [4:0] rdw;
    logic [1:0] resultSrcE;
    logic       regWriteM;
    logic       regWriteW;
    logic       pcSrcE;
    logic       memReqM;
    logic       memAckM;
  } stim_t;

  typedef struct {
    string      tag;
    logic [4:0] en;     // {F, D, E, M, W}
    logic [2:0] clr;    // {D, E, W}
    logic [1:0] fwdA;
    logic [1:0] fwdB;
    logic       memErr;
    int         stallCnt;
    int         flushCnt;
  } exp_t;

  logic          clk;
  logic          rst;
  logic [4:0]    rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
  logic [1:0]    resultSrcE;
  logic          regWriteM, regWriteW, pcSrcE, memReqM, memAckM;
  logic          enF, enD, enE, enM, enW, clrD, clrE, clrW;
  logic [1:0]    forwardAE, forwardBE;
  logic          memErr;
  logic [CW-1:0] stallCnt, flushCnt;

  int   compareCount;
  int   failCount;
  exp_t expQ[$];

  // Model state (value held by the DUT registers after the latest edge).
  logic mWaiting;
  int   mWait;
  logic mErr;
  int   mStall;
  int   mFlush;

  hazard_ctrl #(
    .TIMEOUT   (TO),
    .CNT_WIDTH (CW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .RS1D_i       (rs1d),
    .RS2D_i       (rs2d),
    .RS1E_i       (rs1e),
    .RS2E_i       (rs2e),
    .RDE_i        (rde),
    .RDM_i        (rdm),
    .RDW_i        (rdw),
    .ResultSrcE_i (resultSrcE),
    .RegWriteM_i  (regWriteM),
    .RegWriteW_i  (regWriteW),
    .PCSrcE_i     (pcSrcE),
    .MemReqM_i    (memReqM),
    .MemAckM_i    (memAckM),
    .EnF_o        (enF),
    .EnD_o        (enD),
    .EnE_o        (enE),
    .EnM_o        (enM),
    .EnW_o        (enW),
    .ClrD_o       (clrD),
    .ClrE_o       (clrE),
    .ClrW_o       (clrW),
    .ForwardAE_o  (forwardAE),
    .ForwardBE_o  (forwardBE),
    .MemErr_o     (memErr),
    .StallCnt_o   (stallCnt),
    .FlushCnt_o   (flushCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts and reports every check.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    compareCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, actual, expected);
    end
  endtask

  function automatic logic [1:0] fwdSel(input stim_t s, input logic [4:0] src);
    if (s.regWriteM && s.rdm != 5'd0 && s.rdm == src) return 2'b10;
    if (s.regWriteW && s.rdw != 5'd0 && s.rdw == src) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic memStallOf(input stim_t s);
    if (!mWaiting) return s.memReqM && !s.memAckM;
    return !s.memAckM;
  endfunction

  function automatic logic loadUseOf(input stim_t s);
    return (s.resultSrcE == 2'b01) && (s.rde != 5'd0) &&
           ((s.rde == s.rs1d) || (s.rde == s.rs2d));
  endfunction

  function automatic exp_t modelOutputs(input stim_t s, input string tag);
    exp_t e;
    e.tag = tag;
    if (memStallOf(s)) begin
      e.en = 5'b00001; e.clr = 3'b001;
    end else if (s.pcSrcE) begin
      e.en = 5'b11111; e.clr = 3'b110;
    end else if (loadUseOf(s)) begin
      e.en = 5'b00111; e.clr = 3'b010;
    end else begin
      e.en = 5'b11111; e.clr = 3'b000;
    end
    e.fwdA     = fwdSel(s, s.rs1e);
    e.fwdB     = fwdSel(s, s.rs2e);
    e.memErr   = mErr;
    e.stallCnt = mStall;
    e.flushCnt = mFlush;
    return e;
  endfunction

  task automatic advanceModel(input stim_t s);
    logic ms;
    logic lu;
    ms = memStallOf(s);
    lu = loadUseOf(s);
    if ((ms || (lu && !s.pcSrcE)) && mStall < CntMax) mStall++;
    if (s.pcSrcE && !ms && mFlush < CntMax) mFlush++;
    if (!mWaiting) begin
      if (s.memReqM && !s.memAckM) begin
        mWaiting = 1'b1;
        mWait    = 1;
      end
    end else if (s.memAckM) begin
      mWaiting = 1'b0;
    end else if (mWait == TO - 1) begin
      mWaiting = 1'b0;
      mErr     = 1'b1;
    end else begin
      mWait++;
    end
  endtask

  task automatic resetModel();
    mWaiting = 1'b0;
    mWait    = 0;
    mErr     = 1'b0;
    mStall   = 0;
    mFlush   = 0;
  endtask

  // Drive the DUT inputs and queue the outputs the model expects for them.
  task automatic applyStimulus(input stim_t s, input string tag);
    rs1d = s.rs1d; rs2d = s.rs2d; rs1e = s.rs1e; rs2e = s.rs2e;
    rde = s.rde; rdm = s.rdm; rdw = s.rdw;
    resultSrcE = s.resultSrcE;
    regWriteM = s.regWriteM; regWriteW = s.regWriteW;
    pcSrcE = s.pcSrcE; memReqM = s.memReqM; memAckM = s.memAckM;
    expQ.push_back(modelOutputs(s, tag));
  endtask

  task automatic compareOutputs();
    exp_t e;
    if (expQ.size() == 0) begin
      compareCount++;
      failCount++;
      $display("[TB] FAIL scoreboard: observed empty queue expected an entry");
      return;
    end
    e = expQ.pop_front();
    checkOutput({e.tag, ".en"},  32'({enF, enD, enE, enM, enW}), 32'(e.en));
    checkOutput({e.tag, ".clr"}, 32'({clrD, clrE, clrW}),        32'(e.clr));
    checkOutput({e.tag, ".fwdA"},   32'(forwardAE), 32'(e.fwdA));
    checkOutput({e.tag, ".fwdB"},   32'(forwardBE), 32'(e.fwdB));
    checkOutput({e.tag, ".memErr"}, 32'(memErr),    32'(e.memErr));
    checkOutput({e.tag, ".stall"},  32'(stallCnt),  32'(e.stallCnt));
    checkOutput({e.tag, ".flush"},  32'(flushCnt),  32'(e.flushCnt));
  endtask

  task automatic runCycle(input stim_t s, input string tag);
    @(posedge clk);
    #1;
    applyStimulus(s, tag);
    @(negedge clk);
    compareOutputs();
    advanceModel(s);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed timeout expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    stim_t s;
    stim_t zero;
    int    stallBefore;
    compareCount = 0;
    failCount    = 0;
    zero         = '0;
    resetModel();

    // Reset state, checked while reset is held.
    rst = 1'b1;
    applyStimulus(zero, "reset");
    #3;
    compareOutputs();
    @(negedge clk);
    rst = 1'b0;

    // Forwarding: M wins over W, then W alone, then x0 never forwards.
    s = '0; s.regWriteM = 1; s.rdm = 5; s.rs1e = 5; s.regWriteW = 1; s.rdw = 5;
    runCycle(s, "fwdMprio");
    s.rdm = 0;
    runCycle(s, "fwdW");
    s.rdw = 0; s.rs1e = 0; s.rs2e = 0;
    runCycle(s, "fwdZero");
    s = '0; s.regWriteW = 1; s.rdw = 9; s.rs2e = 9; s.regWriteM = 1; s.rdm = 9;
    s.rs1e = 3;
    runCycle(s, "fwdBM");
    s.regWriteM = 0;
    runCycle(s, "fwdBW");

    // Load-use on RS2D, then the same with x0 as the load target.
    s = '0; s.resultSrcE = 2'b01; s.rde = 7; s.rs2d = 7;
    runCycle(s, "luStall");
    runCycle(zero, "luAfter");
    s.rde = 0; s.rs2d = 0;
    runCycle(s, "luX0");
    s = '0; s.resultSrcE = 2'b00; s.rde = 7; s.rs1d = 7;
    runCycle(s, "luNotLoad");

    // Branch taken together with a load-use: flush wins.
    s = '0; s.pcSrcE = 1; s.resultSrcE = 2'b01; s.rde = 4; s.rs1d = 4;
    runCycle(s, "pcLu");
    runCycle(zero, "pcAfter");

    // Three-cycle memory stall with a branch held; release on the ack.
    stallBefore = mStall;
    s = '0; s.memReqM = 1; s.pcSrcE = 1;
    for (int i = 0; i < 3; i++) runCycle(s, $sformatf("memWait%0d", i));
    s.memAckM = 1;
    runCycle(s, "memAck");
    runCycle(zero, "memDone");
    checkOutput("memStallDelta", 32'(stallCnt), 32'(stallBefore + 3));

    // Request already acknowledged in IDLE: no stall at all.
    s = '0; s.memReqM = 1; s.memAckM = 1;
    runCycle(s, "memFast");
    runCycle(zero, "memFastDone");

    // Timeout: no ack ever, stall for exactly TO cycles then error.
    s = '0; s.memReqM = 1;
    for (int i = 0; i < TO; i++) runCycle(s, $sformatf("toWait%0d", i));
    runCycle(zero, "toAfter");
    s = '0; s.memAckM = 1;
    runCycle(s, "toLateAck");
    runCycle(zero, "toHold");
    checkOutput("memErrSticky", 32'(memErr), 32'd1);

    // Random mix of all hazards.
    for (int i = 0; i < 300; i++) begin
      s.rs1d       = 5'($urandom_range(0, 3));
      s.rs2d       = 5'($urandom_range(0, 3));
      s.rs1e       = 5'($urandom_range(0, 3));
      s.rs2e       = 5'($urandom_range(0, 3));
      s.rde        = 5'($urandom_range(0, 3));
      s.rdm        = 5'($urandom_range(0, 3));
      s.rdw        = 5'($urandom_range(0, 3));
      s.resultSrcE = 2'($urandom_range(0, 3));
      s.regWriteM  = 1'($urandom_range(0, 1));
      s.regWriteW  = 1'($urandom_range(0, 1));
      s.pcSrcE     = ($urandom_range(0, 4) == 0);
      s.memReqM    = 1'($urandom_range(0, 1));
      s.memAckM    = ($urandom_range(0, 3) == 0);
      runCycle(s, $sformatf("rnd%0d", i));
    end
    s = '0; s.memAckM = 1;
    runCycle(s, "rndDrain");

    // Saturation of both counters.
    s = '0; s.resultSrcE = 2'b01; s.rde = 2; s.rs1d = 2;
    for (int i = 0; i < CntMax + 3; i++) runCycle(s, $sformatf("satStall%0d", i));
    s = '0; s.pcSrcE = 1;
    for (int i = 0; i < CntMax + 3; i++) runCycle(s, $sformatf("satFlush%0d", i));
    runCycle(zero, "satDone");
    checkOutput("stallSat", 32'(stallCnt), 32'(CntMax));
    checkOutput("flushSat", 32'(flushCnt), 32'(CntMax));

    // Asynchronous reset in the middle of a memory wait.
    s = '0; s.memReqM = 1;
    runCycle(s, "rstWait0");
    runCycle(s, "rstWait1");
    #2;
    rst = 1'b1;
    resetModel();
    applyStimulus(zero, "rstMid");
    #1;
    compareOutputs();
    @(negedge clk);
    applyStimulus(zero, "rstHold");
    compareOutputs();
    rst = 1'b0;
    runCycle(zero, "rstAfter0");
    runCycle(zero, "rstAfter1");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

endmodule
